// File: rtl/apb_sincos_pkg.sv
`default_nettype none
// ============================================================================
// Module : apb_sincos_pkg
// Brief  : Shared definitions for the APB sin/cos generator. This package
//          holds the register offsets, the CTRL/STATUS bit indices, the
//          compute-FSM state type, and the constant function that builds
//          the quarter-wave table.
// Rev    : 1.0  initial release
// ============================================================================
package apb_sincos_pkg;

    // Register byte offsets (PADDR[4:0])
    localparam logic [4:0] c_addr_ctrl   = 5'h00;
    localparam logic [4:0] c_addr_phase  = 5'h04;
    localparam logic [4:0] c_addr_step   = 5'h08;
    localparam logic [4:0] c_addr_sin    = 5'h0C;
    localparam logic [4:0] c_addr_cos    = 5'h10;
    localparam logic [4:0] c_addr_status = 5'h14;

    // CTRL / STATUS bit positions
    localparam int c_ctrl_auto   = 0;
    localparam int c_ctrl_irq_en = 1;
    localparam int c_status_busy = 0;
    localparam int c_status_done = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_SIN = 2'd1,
        RD_COS = 2'd2,
        WB     = 2'd3
    } state_t;

    // Fixed-point helpers for the table generator (2^30 scaling)
    localparam longint c_fx_one = 64'sd1073741824;
    localparam longint c_fx_pi  = 64'sd3373259426;

    // round(full_scale * sin(k*pi/(2q))) evaluated at elaboration time with a
    // Taylor series in 64-bit fixed point. The angle never exceeds pi/2, so
    // every intermediate product stays below 2^62. The truncation error is
    // around 1e-9, which is far below one output LSB.
    function automatic longint f_rom_value(input int k, input int q, input longint full_scale);
        longint x;
        longint term;
        longint sum;
        x    = (c_fx_pi * longint'(k)) / (64'sd2 * longint'(q));
        term = x;
        sum  = x;
        for (int n = 1; n <= 8; n++) begin
            term = -((term * x) / c_fx_one);
            term = (term * x) / c_fx_one;
            term = term / longint'((2 * n) * (2 * n + 1));
            sum  = sum + term;
        end
        return (sum * full_scale + c_fx_one / 2) / c_fx_one;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sincos_quarter_rom.sv
`default_nettype none
// ============================================================================
// Module : sincos_quarter_rom
// Brief  : Quarter-wave sine table with a one-cycle synchronous read.
//          Entry k holds round((2^(DATA_W-1)-1) * sin(k*pi/(2Q))), where
//          Q = 2^(PHASE_BITS-2) and k = 0..Q. Addresses above Q return 0.
// Ports  : clk     in   clock
//          rst_n   in   asynchronous active-low reset (clears the output)
//          i_addr  in   table index, PHASE_BITS-1 bits
//          o_data  out  registered unsigned magnitude, DATA_W bits
// Rev    : 1.0  initial release
// ============================================================================
module sincos_quarter_rom
    import apb_sincos_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int PHASE_BITS = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [PHASE_BITS-2:0] i_addr,
    output logic [DATA_W-1:0]     o_data
);

    localparam int     c_q           = 1 << (PHASE_BITS - 2);
    localparam int     c_entries     = 1 << (PHASE_BITS - 1);
    localparam longint c_full_scale  = (longint'(1) << (DATA_W - 1)) - 1;

    // The table spans the full address range, so an index can never fall
    // outside it. Slots above Q are never addressed by the fold logic.
    logic [DATA_W-1:0] w_table [c_entries];

    for (genvar k = 0; k < c_entries; k++) begin : g_rom
        localparam logic [DATA_W-1:0] c_entry =
            (k <= c_q) ? DATA_W'(f_rom_value(k, c_q, c_full_scale)) : {DATA_W{1'b0}};
        assign w_table[k] = c_entry;
    end

    logic [DATA_W-1:0] r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
        end else begin
            r_data <= w_table[i_addr];
        end
    end

    assign o_data = r_data;

endmodule
`default_nettype wire

// File: rtl/apb_sincos_gen.sv
`default_nettype none
// ============================================================================
// Module : apb_sincos_gen
// Brief  : APB3 slave that computes signed Q1.(DATA_W-1) sin and cos of
//          phase p*2*pi/2^PHASE_BITS. It folds a quarter-wave table and runs
//          a 3-cycle compute FSM. A SIN/COS read during a compute is held
//          with wait states. Optional auto-step (NCO sweep) and a level
//          done interrupt are provided.
// Ports  : PCLK     in   clock
//          PRESETn  in   asynchronous active-low reset
//          PSEL     in   APB select
//          PENABLE  in   APB access phase
//          PWRITE   in   1 = write, 0 = read
//          PADDR    in   byte address, [4:0] decoded
//          PWDATA   in   write data
//          PRDATA   out  read data (sin/cos sign-extended)
//          PREADY   out  transfer complete (combinational)
//          PSLVERR  out  unmapped address or write to SIN/COS
//          irq      out  STATUS.DONE & CTRL.IRQ_EN
// Rev    : 1.0  initial release
// ============================================================================
module apb_sincos_gen
    import apb_sincos_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int PHASE_BITS = 6
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic        irq
);

    // Q as a table address and as a phase offset (quarter period)
    localparam logic [PHASE_BITS-2:0] c_q_addr  = {1'b1, {(PHASE_BITS-2){1'b0}}};
    localparam logic [PHASE_BITS-1:0] c_q_phase = {2'b01, {(PHASE_BITS-2){1'b0}}};

    state_t                r_state;
    logic [1:0]            r_ctrl;
    logic [PHASE_BITS-1:0] r_phase;
    logic [PHASE_BITS-1:0] r_step;
    logic [DATA_W-1:0]     r_sin;
    logic [DATA_W-1:0]     r_cos;
    logic [DATA_W-1:0]     r_sin_mag;
    logic                  r_done;

    logic                  w_access;
    logic                  w_busy;
    logic [4:0]            w_addr;
    logic                  w_is_ctrl, w_is_phase, w_is_step, w_is_sin, w_is_cos, w_is_status;
    logic                  w_mapped;
    logic                  w_ro_write;
    logic                  w_stall;
    logic                  w_wr_ok;
    logic                  w_rd_ok;
    logic                  w_phase_wr;
    logic                  w_auto_step;
    logic                  w_start;
    logic [PHASE_BITS-1:0] w_phase_next;
    logic [PHASE_BITS-1:0] w_cos_phase;
    logic [PHASE_BITS-1:0] w_rom_phase;
    logic [PHASE_BITS-3:0] w_idx;
    logic [PHASE_BITS-2:0] w_rom_addr;
    logic [DATA_W-1:0]     w_rom_data;
    logic [31:0]           w_rdata;
    logic                  w_unused;

    // ------------------------------------------------------------------
    // APB decode and handshake
    // ------------------------------------------------------------------
    assign w_access    = PSEL & PENABLE;
    assign w_busy      = (r_state != IDLE);
    assign w_addr      = PADDR[4:0];
    assign w_is_ctrl   = (w_addr == c_addr_ctrl);
    assign w_is_phase  = (w_addr == c_addr_phase);
    assign w_is_step   = (w_addr == c_addr_step);
    assign w_is_sin    = (w_addr == c_addr_sin);
    assign w_is_cos    = (w_addr == c_addr_cos);
    assign w_is_status = (w_addr == c_addr_status);
    assign w_mapped    = w_is_ctrl | w_is_phase | w_is_step | w_is_sin | w_is_cos | w_is_status;
    assign w_ro_write  = PWRITE & (w_is_sin | w_is_cos);

    // A result read during a compute waits until the writeback has landed.
    assign w_stall     = ~PWRITE & (w_is_sin | w_is_cos) & w_busy;
    assign PREADY      = w_access & ~w_stall;
    assign PSLVERR     = PREADY & (~w_mapped | w_ro_write);

    assign w_wr_ok     = PREADY & PWRITE & w_mapped & ~w_ro_write;
    assign w_rd_ok     = PREADY & ~PWRITE & w_mapped;

    assign w_phase_wr  = w_wr_ok & w_is_phase;
    assign w_auto_step = w_rd_ok & w_is_cos & r_ctrl[c_ctrl_auto] & ~w_busy;
    assign w_start     = w_phase_wr | w_auto_step;
    assign w_phase_next = w_phase_wr ? PWDATA[PHASE_BITS-1:0] : (r_phase + r_step);

    always_comb begin
        w_rdata = '0;
        case (w_addr)
            c_addr_ctrl:   w_rdata = 32'(r_ctrl);
            c_addr_phase:  w_rdata = 32'(r_phase);
            c_addr_step:   w_rdata = 32'(r_step);
            c_addr_sin:    w_rdata = 32'(signed'(r_sin));
            c_addr_cos:    w_rdata = 32'(signed'(r_cos));
            c_addr_status: w_rdata = 32'({r_done, w_busy});
            default:       w_rdata = '0;
        endcase
    end

    // The read mux only changes at writeback, so data stays stable during a
    // stalled read and then shows the new value when PREADY rises.
    assign PRDATA = (w_access & ~PWRITE) ? w_rdata : 32'd0;

    assign irq = r_done & r_ctrl[c_ctrl_irq_en];

    // ------------------------------------------------------------------
    // Quadrant fold: quadrants 1 and 3 mirror the table (Q - idx).
    // RD_SIN addresses sin(p); RD_COS addresses sin(p+Q) = cos(p).
    // ------------------------------------------------------------------
    assign w_cos_phase = r_phase + c_q_phase;
    assign w_rom_phase = (r_state == RD_COS) ? w_cos_phase : r_phase;
    assign w_idx       = w_rom_phase[PHASE_BITS-3:0];
    assign w_rom_addr  = w_rom_phase[PHASE_BITS-2] ? (c_q_addr - {1'b0, w_idx})
                                                   : {1'b0, w_idx};

    sincos_quarter_rom #(
        .DATA_W     (DATA_W),
        .PHASE_BITS (PHASE_BITS)
    ) u_rom (
        .clk    (PCLK),
        .rst_n  (PRESETn),
        .i_addr (w_rom_addr),
        .o_data (w_rom_data)
    );

    // ------------------------------------------------------------------
    // Registers and compute FSM
    // ------------------------------------------------------------------
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state   <= IDLE;
            r_ctrl    <= '0;
            r_phase   <= '0;
            r_step    <= '0;
            r_sin     <= '0;
            r_cos     <= '0;
            r_sin_mag <= '0;
            r_done    <= 1'b0;
        end else begin
            if (w_wr_ok && w_is_ctrl) begin
                r_ctrl <= PWDATA[1:0];
            end
            if (w_wr_ok && w_is_step) begin
                r_step <= PWDATA[PHASE_BITS-1:0];
            end
            if (w_start) begin
                r_phase <= w_phase_next;
            end

            // A completing writeback takes priority over a same-cycle W1C.
            if (r_state == WB && !w_start) begin
                r_done <= 1'b1;
            end else if (w_wr_ok && w_is_status && PWDATA[c_status_done]) begin
                r_done <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    r_state <= IDLE;
                end
                RD_SIN: begin
                    r_state <= RD_COS;
                end
                RD_COS: begin
                    r_sin_mag <= w_rom_data;
                    r_state   <= WB;
                end
                WB: begin
                    // A restart arriving in this cycle discards the old result.
                    if (!w_start) begin
                        r_sin <= r_phase[PHASE_BITS-1]     ? -r_sin_mag  : r_sin_mag;
                        r_cos <= w_cos_phase[PHASE_BITS-1] ? -w_rom_data : w_rom_data;
                    end
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase

            // New phase (write or auto-step) restarts the compute from scratch.
            if (w_start) begin
                r_state <= RD_SIN;
            end
        end
    end

    assign w_unused = ^{PADDR[31:5], PWDATA[31:PHASE_BITS]};

endmodule
`default_nettype wire

// File: tb/tb_apb_sincos_gen.sv
`default_nettype none
// ============================================================================
// Module : tb_apb_sincos_gen
// Brief  : Self-checking bench for apb_sincos_gen. Expected sin/cos words
//          come from a real-valued model and are queued when a compute is
//          launched, then popped when the results are read back.
// Rev    : 1.0  initial release
// ============================================================================
module tb_apb_sincos_gen;

    localparam int DATA_W     = 16;
    localparam int PHASE_BITS = 6;
    localparam int NSTEPS     = 1 << PHASE_BITS;

    localparam logic [31:0] A_CTRL   = 32'h00;
    localparam logic [31:0] A_PHASE  = 32'h04;
    localparam logic [31:0] A_STEP   = 32'h08;
    localparam logic [31:0] A_SIN    = 32'h0C;
    localparam logic [31:0] A_COS    = 32'h10;
    localparam logic [31:0] A_STATUS = 32'h14;
    localparam logic [31:0] A_BAD    = 32'h18;

    logic        PCLK    = 1'b0;
    logic        PRESETn = 1'b0;
    logic        PSEL    = 1'b0;
    logic        PENABLE = 1'b0;
    logic        PWRITE  = 1'b0;
    logic [31:0] PADDR   = '0;
    logic [31:0] PWDATA  = '0;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic        irq;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          phase;
        logic [31:0] s;
        logic [31:0] c;
    } exp_t;

    exp_t sb[$];

    apb_sincos_gen #(
        .DATA_W     (DATA_W),
        .PHASE_BITS (PHASE_BITS)
    ) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR),
        .irq     (irq)
    );

    always #5 PCLK = ~PCLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    function automatic logic [31:0] model(input int p, input bit want_cos);
        real a;
        real v;
        int  r;
        a = 2.0 * 3.14159265358979323846 * real'(p) / real'(NSTEPS);
        v = real'((1 << (DATA_W - 1)) - 1) * (want_cos ? $cos(a) : $sin(a));
        if (v >= 0.0) r = $rtoi(v + 0.5);
        else          r = -$rtoi(0.5 - v);
        return r;
    endfunction

    task automatic push_expected(input int p);
        exp_t e;
        e.phase = p % NSTEPS;
        e.s     = model(e.phase, 1'b0);
        e.c     = model(e.phase, 1'b1);
        sb.push_back(e);
    endtask

    // ------------------------------------------------------------------
    // APB master. Each task is entered and left 1 time unit after a
    // rising edge. Signals are sampled 2 time units after an edge.
    // ------------------------------------------------------------------
    task automatic apb_write(input logic [31:0] a, input logic [31:0] d, output logic err);
        int waits;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
        @(posedge PCLK); #1; PENABLE = 1'b1; #1;
        waits = 0;
        while (!PREADY && waits < 60) begin
            waits++;
            @(posedge PCLK); #2;
        end
        if (!PREADY) begin
            checks++; errors++;
            $display("FAIL apb_write_timeout addr=%h: PREADY got 0 expected 1", a);
        end
        err = PSLVERR;
        @(posedge PCLK); #1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] a, output logic [31:0] d, output logic err,
                            output int lows);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a; PWDATA = '0;
        #1;
        lows = PREADY ? 0 : 1;
        @(posedge PCLK); #1; PENABLE = 1'b1; #1;
        while (!PREADY && lows < 60) begin
            lows++;
            @(posedge PCLK); #2;
        end
        if (!PREADY) begin
            checks++; errors++;
            $display("FAIL apb_read_timeout addr=%h: PREADY got 0 expected 1", a);
        end
        d   = PRDATA;
        err = PSLVERR;
        @(posedge PCLK); #1; PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic check_results(input string name);
        exp_t        e;
        logic [31:0] d;
        logic        err;
        int          lows;
        if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s_scoreboard: queue empty, got 0 entries expected 1", name);
            return;
        end
        e = sb.pop_front();
        apb_read(A_SIN, d, err, lows);
        checks++;
        if (d !== e.s || err !== 1'b0) begin
            errors++;
            $display("FAIL %s_sin phase=%0d: got %h err=%b expected %h err=0", name, e.phase, d, err, e.s);
        end
        apb_read(A_COS, d, err, lows);
        checks++;
        if (d !== e.c || err !== 1'b0) begin
            errors++;
            $display("FAIL %s_cos phase=%0d: got %h err=%b expected %h err=0", name, e.phase, d, err, e.c);
        end
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        logic [31:0] d;
        logic        err;
        int          lows;
        logic [31:0] addrs [6];
        addrs = '{A_CTRL, A_PHASE, A_STEP, A_SIN, A_COS, A_STATUS};

        // Outputs during reset
        #1;
        checks++;
        if ({PRDATA, PREADY, PSLVERR, irq} !== 35'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", {PRDATA, PREADY, PSLVERR, irq});
        end
        repeat (3) @(posedge PCLK);
        #1; PRESETn = 1'b1;

        for (int i = 0; i < 6; i++) begin
            apb_read(addrs[i], d, err, lows);
            checks++;
            if (d !== 32'd0 || err !== 1'b0) begin
                errors++;
                $display("FAIL reset_reg addr=%h: got %h err=%b expected 0 err=0", addrs[i], d, err);
            end
        end

        // Set up a completed result and pending irq, then reset mid-compute
        apb_write(A_CTRL, 32'h2, err);
        apb_write(A_PHASE, 32'd16, err);
        push_expected(16);
        check_results("pre_reset");
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_irq: got %b expected 1", irq);
        end
        apb_write(A_PHASE, 32'd8, err);     // completes at T, now in T+1
        @(posedge PCLK); #1;                 // T+2
        PRESETn = 1'b0;
        #1;
        checks++;
        if ({PRDATA, PREADY, PSLVERR, irq} !== 35'd0) begin
            errors++;
            $display("FAIL midreset_outputs: got %h expected 0", {PRDATA, PREADY, PSLVERR, irq});
        end
        repeat (2) @(posedge PCLK);
        #1; PRESETn = 1'b1;
        repeat (6) @(posedge PCLK);
        #1;
        for (int i = 0; i < 6; i++) begin
            apb_read(addrs[i], d, err, lows);
            checks++;
            if (d !== 32'd0) begin
                errors++;
                $display("FAIL midreset_reg addr=%h: got %h expected 0", addrs[i], d);
            end
        end
    endtask

    task automatic test_quadrants();
        logic err;
        int   phases [5];
        phases = '{0, 16, 32, 48, 8};
        for (int i = 0; i < 5; i++) begin
            apb_write(A_PHASE, 32'(phases[i]), err);
            push_expected(phases[i]);
            check_results("quadrant");
        end
    endtask

    task automatic test_sweep();
        logic err;
        int   p;
        for (int i = 0; i < 8; i++) begin
            p = int'($urandom_range(NSTEPS - 1, 0));
            apb_write(A_PHASE, 32'(p), err);
            push_expected(p);
            check_results("sweep");
        end
    endtask

    task automatic test_latency();
        logic [31:0] d;
        logic        err;
        int          lows;
        apb_write(A_STATUS, 32'h2, err);
        apb_write(A_PHASE, 32'd20, err);    // completes at T
        push_expected(20);
        apb_read(A_STATUS, d, err, lows);   // access at T+2
        checks++;
        if (d !== 32'h1 || lows !== 1) begin
            errors++;
            $display("FAIL latency_busy: got status %h lows %0d expected 00000001 lows 1", d, lows);
        end
        apb_read(A_STATUS, d, err, lows);   // access at T+4
        checks++;
        if (d !== 32'h2) begin
            errors++;
            $display("FAIL latency_done: got status %h expected 00000002", d);
        end
        check_results("latency");
    endtask

    task automatic test_wait_state();
        logic [31:0] d;
        logic        err;
        int          lows;
        exp_t        e;
        apb_write(A_PHASE, 32'd40, err);
        push_expected(40);
        apb_read(A_SIN, d, err, lows);      // setup at T+1
        e = sb.pop_front();
        checks++;
        if (lows !== 3 || d !== e.s) begin
            errors++;
            $display("FAIL wait_state_sin: got lows %0d data %h expected lows 3 data %h", lows, d, e.s);
        end
        apb_read(A_COS, d, err, lows);
        checks++;
        if (lows !== 1 || d !== e.c) begin
            errors++;
            $display("FAIL wait_state_cos: got lows %0d data %h expected lows 1 data %h", lows, d, e.c);
        end
    endtask

    task automatic test_auto();
        logic [31:0] d;
        logic        err;
        int          lows;
        exp_t        e;
        apb_write(A_STEP, 32'd8, err);
        apb_write(A_CTRL, 32'd3, err);
        apb_write(A_STATUS, 32'h2, err);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL auto_irq_cleared: got %b expected 0", irq);
        end
        apb_write(A_PHASE, 32'd60, err);
        push_expected(60);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL auto_irq_early: got %b expected 0", irq);
        end
        e = sb.pop_front();
        apb_read(A_SIN, d, err, lows);
        checks++;
        if (d !== e.s) begin
            errors++;
            $display("FAIL auto_sin60: got %h expected %h", d, e.s);
        end
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL auto_irq_rise: got %b expected 1", irq);
        end
        apb_read(A_COS, d, err, lows);      // triggers PHASE = 60 + 8 mod 64
        push_expected(60 + 8);
        checks++;
        if (d !== e.c) begin
            errors++;
            $display("FAIL auto_cos60: got %h expected %h", d, e.c);
        end
        apb_write(A_CTRL, 32'd2, err);      // stop stepping before reading again
        apb_read(A_PHASE, d, err, lows);
        checks++;
        if (d !== 32'd4) begin
            errors++;
            $display("FAIL auto_phase_wrap: got %h expected 00000004", d);
        end
        check_results("auto_step");
        apb_write(A_STATUS, 32'h2, err);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL auto_irq_clear: got %b expected 0", irq);
        end
    endtask

    task automatic test_errors();
        logic [31:0] d;
        logic        err;
        int          lows;
        logic [31:0] sin_before;
        apb_read(A_SIN, sin_before, err, lows);
        checks++;
        if (sin_before !== model(4, 1'b0)) begin
            errors++;
            $display("FAIL err_sin_before: got %h expected %h", sin_before, model(4, 1'b0));
        end
        apb_read(A_BAD, d, err, lows);
        checks++;
        if (err !== 1'b1 || d !== 32'd0 || lows !== 1) begin
            errors++;
            $display("FAIL err_unmapped_read: got err %b data %h lows %0d expected err 1 data 0 lows 1", err, d, lows);
        end
        apb_write(A_SIN, 32'h0000_1234, err);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_ro_write_sin: got err %b expected 1", err);
        end
        apb_write(A_COS, 32'h0000_4321, err);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_ro_write_cos: got err %b expected 1", err);
        end
        apb_write(A_STEP, 32'd3, err);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_good_write: got err %b expected 0", err);
        end
        apb_read(A_SIN, d, err, lows);
        checks++;
        if (d !== sin_before || err !== 1'b0) begin
            errors++;
            $display("FAIL err_sin_kept: got %h err %b expected %h err 0", d, err, sin_before);
        end
        apb_read(A_STATUS, d, err, lows);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL err_no_compute: got status %h expected 0", d);
        end
    endtask

    task automatic test_simultaneous();
        logic [31:0] d;
        logic        err;
        int          lows;
        // Restart while busy: only the second phase may show up
        apb_write(A_PHASE, 32'd10, err);
        apb_write(A_PHASE, 32'd44, err);
        push_expected(44);
        check_results("restart");

        // STEP write alone must not launch a compute
        apb_write(A_STATUS, 32'h2, err);
        apb_write(A_STEP, 32'd5, err);
        apb_read(A_STATUS, d, err, lows);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL step_no_start: got status %h expected 0", d);
        end

        // DONE set (WB at T+3) and W1C in the same cycle: set wins
        apb_write(A_PHASE, 32'd24, err);
        push_expected(24);
        @(posedge PCLK); #1;                 // T+2
        apb_write(A_STATUS, 32'h2, err);     // access at T+3
        apb_read(A_STATUS, d, err, lows);
        checks++;
        if (d !== 32'h2) begin
            errors++;
            $display("FAIL done_set_wins: got status %h expected 00000002", d);
        end
        check_results("set_wins");
    endtask

    initial begin
        test_reset();
        test_quadrants();
        test_latency();
        test_wait_state();
        test_sweep();
        test_auto();
        test_errors();
        test_simultaneous();
        if (sb.size() != 0) begin
            checks++; errors++;
            $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
